poll_ctrl: RTL and testbench

POLL_CTRL -- requirements
Module: poll_ctrl

---
 rtl/poll_ctrl_pkg.sv | 32 +++
 rtl/poll_timer.sv | 47 ++++
 rtl/poll_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_poll_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poll_ctrl_pkg.sv
// rtl/poll_ctrl_pkg.sv - shared codes and encodings for the Polling controller
//
// Purpose: the single home of the LTSSM state/sub-state codes placed on
// ts_info, the Polling FSM encoding and the datapath widths. Every other file
// imports this package instead of redefining any of these values.
// Ports: none (package).

package poll_ctrl_pkg;

  // LTSSM state / sub-state codes, concatenated as {state, sub_state} on ts_info
  localparam logic [3:0] ST_POLL         = 4'h2;
  localparam logic [3:0] SUB_POLL_ACTIVE = 4'hA;
  localparam logic [3:0] SUB_POLL_CFG    = 4'hC;

  // Datapath widths
  localparam int TIMER_W = 17;
  localparam int SENT_W  = 16;

  // Polling FSM encoding, also exported on poll_state
  typedef enum logic [2:0] {
    POLL_IDLE    = 3'd0,
    POLL_ACT_REQ = 3'd1,
    POLL_ACTIVE  = 3'd2,
    POLL_CFG_REQ = 3'd3,
    POLL_CONFIG  = 3'd4
  } poll_state_e;

  function automatic logic [7:0] ts_info_code(input logic [3:0] st, input logic [3:0] sub);
    return {st, sub};
  endfunction

endpackage

// File: rtl/poll_timer.sv
// rtl/poll_timer.sv - saturating cycle timer with limit compare
//
// Purpose: counts clock cycles since the last clear and flags when the
// programmed limit has been reached.
// Ports:
//   clk_i      in   clock
//   rst_i      in   asynchronous active-high reset
//   clear_i    in   restart the count from zero on the next edge
//   limit_i    in   cycle limit, TIMER_W bits
//   expired_o  out  limit reached (see note below)

module poll_timer
  import poll_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic [TIMER_W-1:0] limit_i,
  output logic               expired_o
);

  localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The consumer registers its reaction one edge later, so expiry is flagged
  // on count limit-1: the resulting exit lands exactly limit cycles after clear.
  assign expired_o = (limit_i == '0) || (count_q >= (limit_i - ONE));

endmodule

// File: rtl/poll_ctrl.sv
// rtl/poll_ctrl.sv - LTSSM Polling sub-state controller
//
// Purpose: sequences Polling.Active and Polling.Configuration, hands the
// current {state, sub_state} to the TS analyzer with a request/ack handshake,
// counts transmitted TS ordered sets and applies the per-sub-state timeouts.
// Ports:
//   clk                    in   system clock
//   rst                    in   asynchronous active-high reset
//   poll_start             in   pulse: enter Polling from Detect
//   tx_ts_strobe           in   one TS ordered set transmitted this cycle
//   ts_update_ack          in   analyzer accepted ts_info
//   tsa_p_a2c              in   analyzer: Active -> Configuration condition met
//   tsa_p2c                in   analyzer: Configuration exit condition met
//   ts_info                out  {state, sub_state} for the analyzer
//   ts_update              out  level request to load ts_info
//   ts_stop                out  pulse: stop TS analysis/transmission
//   to_tsa_ts_sent_enough  out  transmit count target reached
//   poll_state             out  FSM state encoding
//   goto_cfg               out  pulse: exit to Configuration
//   goto_detect            out  pulse: exit to Detect on timeout

module poll_ctrl
  import poll_ctrl_pkg::*;
#(
  parameter int TX_TS_ACT   = 1024,
  parameter int TX_TS_CFG   = 16,
  parameter int TIMEOUT_ACT = 24000,
  parameter int TIMEOUT_CFG = 48000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_start,
  input  logic       tx_ts_strobe,
  input  logic       ts_update_ack,
  input  logic       tsa_p_a2c,
  input  logic       tsa_p2c,
  output logic [7:0] ts_info,
  output logic       ts_update,
  output logic       ts_stop,
  output logic       to_tsa_ts_sent_enough,
  output logic [2:0] poll_state,
  output logic       goto_cfg,
  output logic       goto_detect
);

  localparam logic [SENT_W-1:0]  SENT_ACT = SENT_W'(TX_TS_ACT);
  localparam logic [SENT_W-1:0]  SENT_CFG = SENT_W'(TX_TS_CFG);
  localparam logic [SENT_W-1:0]  SENT_ONE = SENT_W'(1);
  localparam logic [TIMER_W-1:0] TO_ACT   = TIMER_W'(TIMEOUT_ACT);
  localparam logic [TIMER_W-1:0] TO_CFG   = TIMER_W'(TIMEOUT_CFG);

  poll_state_e        state_q, state_d;
  logic [SENT_W-1:0]  sent_q, sent_d;
  logic [7:0]         ts_info_q, ts_info_d;
  logic               ts_update_q, ts_update_d;
  logic               ts_stop_q, ts_stop_d;
  logic               enough_q, enough_d;
  logic               goto_cfg_q, goto_cfg_d;
  logic               goto_detect_q, goto_detect_d;

  logic               timer_clear;
  logic               timer_expired;
  logic [TIMER_W-1:0] timer_limit;

  poll_timer u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .clear_i   (timer_clear),
    .limit_i   (timer_limit),
    .expired_o (timer_expired)
  );

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= POLL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  // Success conditions are tested before the timeout so they win a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      POLL_IDLE: begin
        if (poll_start) state_d = POLL_ACT_REQ;
      end
      POLL_ACT_REQ: begin
        if (ts_update_ack)      state_d = POLL_ACTIVE;
        else if (timer_expired) state_d = POLL_IDLE;
      end
      POLL_ACTIVE: begin
        if (tsa_p_a2c)          state_d = POLL_CFG_REQ;
        else if (timer_expired) state_d = POLL_IDLE;
      end
      POLL_CFG_REQ: begin
        if (ts_update_ack)      state_d = POLL_CONFIG;
        else if (timer_expired) state_d = POLL_IDLE;
      end
      POLL_CONFIG: begin
        if (tsa_p2c)            state_d = POLL_IDLE;
        else if (timer_expired) state_d = POLL_IDLE;
      end
      default: state_d = POLL_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs / datapath
  always_comb begin
    ts_info_d     = ts_info_q;
    ts_update_d   = 1'b0;
    goto_cfg_d    = 1'b0;
    goto_detect_d = 1'b0;
    ts_stop_d     = 1'b0;
    enough_d      = 1'b0;
    sent_d        = sent_q;
    timer_clear   = 1'b0;
    timer_limit   = TO_CFG;

    if (state_q == POLL_ACT_REQ || state_q == POLL_ACTIVE) begin
      timer_limit = TO_ACT;
    end

    // The timer restarts when a handshake state is entered and keeps running
    // through the handshake into the following sub-state.
    if ((state_d == POLL_ACT_REQ && state_q != POLL_ACT_REQ) ||
        (state_d == POLL_CFG_REQ && state_q != POLL_CFG_REQ)) begin
      timer_clear = 1'b1;
    end

    if (state_d == POLL_ACT_REQ) begin
      ts_info_d   = ts_info_code(ST_POLL, SUB_POLL_ACTIVE);
      ts_update_d = 1'b1;
    end else if (state_d == POLL_CFG_REQ) begin
      ts_info_d   = ts_info_code(ST_POLL, SUB_POLL_CFG);
      ts_update_d = 1'b1;
    end

    // Any fall back to IDLE is an exit: success from CONFIG, otherwise timeout.
    if (state_q != POLL_IDLE && state_d == POLL_IDLE) begin
      if (state_q == POLL_CONFIG && tsa_p2c) goto_cfg_d = 1'b1;
      else                                   goto_detect_d = 1'b1;
      ts_stop_d = 1'b1;
    end

    // Sent counter: cleared on handshake completion, saturating increment.
    if ((state_q == POLL_ACT_REQ && state_d == POLL_ACTIVE) ||
        (state_q == POLL_CFG_REQ && state_d == POLL_CONFIG)) begin
      sent_d = '0;
    end else if ((state_q == POLL_ACTIVE || state_q == POLL_CONFIG) &&
                 tx_ts_strobe && sent_q != '1) begin
      sent_d = sent_q + SENT_ONE;
    end

    // Gated on staying in the sub-state so the flag drops with the exit edge.
    if (state_q == POLL_ACTIVE && state_d == POLL_ACTIVE && sent_q >= SENT_ACT) begin
      enough_d = 1'b1;
    end
    if (state_q == POLL_CONFIG && state_d == POLL_CONFIG && sent_q >= SENT_CFG) begin
      enough_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_q        <= '0;
      ts_info_q     <= '0;
      ts_update_q   <= 1'b0;
      ts_stop_q     <= 1'b0;
      enough_q      <= 1'b0;
      goto_cfg_q    <= 1'b0;
      goto_detect_q <= 1'b0;
    end else begin
      sent_q        <= sent_d;
      ts_info_q     <= ts_info_d;
      ts_update_q   <= ts_update_d;
      ts_stop_q     <= ts_stop_d;
      enough_q      <= enough_d;
      goto_cfg_q    <= goto_cfg_d;
      goto_detect_q <= goto_detect_d;
    end
  end

  assign ts_info               = ts_info_q;
  assign ts_update             = ts_update_q;
  assign ts_stop               = ts_stop_q;
  assign to_tsa_ts_sent_enough = enough_q;
  assign poll_state            = state_q;
  assign goto_cfg              = goto_cfg_q;
  assign goto_detect           = goto_detect_q;

endmodule

// File: tb/tb_poll_ctrl.sv
// tb/tb_poll_ctrl.sv - directed self-checking bench for poll_ctrl

module tb_poll_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       poll_start, tx_ts_strobe, ts_update_ack, tsa_p_a2c, tsa_p2c;
  logic [7:0] ts_info;
  logic       ts_update, ts_stop, enough, goto_cfg, goto_detect;
  logic [2:0] poll_state;

  logic       s_poll_start, s_strobe, s_ack;
  logic       s_a2c, s_p2c;
  logic [7:0] s_ts_info;
  logic       s_ts_update, s_ts_stop, s_enough, s_goto_cfg, s_goto_detect;
  logic [2:0] s_state;

  int checks = 0;
  int failures = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  poll_ctrl #(.TX_TS_ACT(8), .TX_TS_CFG(4), .TIMEOUT_ACT(200), .TIMEOUT_CFG(400)) dut (
    .clk(clk), .rst(rst), .poll_start(poll_start), .tx_ts_strobe(tx_ts_strobe),
    .ts_update_ack(ts_update_ack), .tsa_p_a2c(tsa_p_a2c), .tsa_p2c(tsa_p2c),
    .ts_info(ts_info), .ts_update(ts_update), .ts_stop(ts_stop),
    .to_tsa_ts_sent_enough(enough), .poll_state(poll_state),
    .goto_cfg(goto_cfg), .goto_detect(goto_detect)
  );

  poll_ctrl #(.TX_TS_ACT(8), .TX_TS_CFG(4), .TIMEOUT_ACT(100000), .TIMEOUT_CFG(400)) u_sat (
    .clk(clk), .rst(rst), .poll_start(s_poll_start), .tx_ts_strobe(s_strobe),
    .ts_update_ack(s_ack), .tsa_p_a2c(s_a2c), .tsa_p2c(s_p2c),
    .ts_info(s_ts_info), .ts_update(s_ts_update), .ts_stop(s_ts_stop),
    .to_tsa_ts_sent_enough(s_enough), .poll_state(s_state),
    .goto_cfg(s_goto_cfg), .goto_detect(s_goto_detect)
  );

  always @(negedge clk) if (goto_cfg && goto_detect) both_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enter_cfg_req;
    poll_start = 1'b1; tick; poll_start = 1'b0;
    ts_update_ack = 1'b1; tick; ts_update_ack = 1'b0;
    tsa_p_a2c = 1'b1; tick; tsa_p_a2c = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    poll_start = 0; tx_ts_strobe = 0; ts_update_ack = 0; tsa_p_a2c = 0; tsa_p2c = 0;
    s_poll_start = 0; s_strobe = 0; s_ack = 0; s_a2c = 0; s_p2c = 0;
    tick; tick; tick;
    checks++;
    if ({ts_info, ts_update, ts_stop, enough, poll_state, goto_cfg, goto_detect} !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0000",
               {ts_info, ts_update, ts_stop, enough, poll_state, goto_cfg, goto_detect});
    end
    rst = 1'b0;
    tsa_p_a2c = 1'b1; tsa_p2c = 1'b1; tick; tsa_p_a2c = 1'b0; tsa_p2c = 1'b0;
    checks++;
    if (poll_state !== 3'd0 || ts_update !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_flags got state=%0d upd=%b exp state=0 upd=0", poll_state, ts_update);
    end
  endtask

  task automatic test_happy_path;
    poll_start = 1'b1; tick; poll_start = 1'b0;
    checks++;
    if (poll_state !== 3'd1 || ts_info !== 8'h2A || ts_update !== 1'b1) begin
      failures++;
      $display("FAIL act_req_entry got state=%0d info=%h upd=%b exp 1 2a 1", poll_state, ts_info, ts_update);
    end
    tick;
    checks++;
    if (poll_state !== 3'd1 || ts_update !== 1'b1) begin
      failures++;
      $display("FAIL act_req_hold got state=%0d upd=%b exp 1 1", poll_state, ts_update);
    end
    ts_update_ack = 1'b1; tick; ts_update_ack = 1'b0;
    checks++;
    if (poll_state !== 3'd2 || ts_update !== 1'b0) begin
      failures++;
      $display("FAIL active_entry got state=%0d upd=%b exp 2 0", poll_state, ts_update);
    end
    poll_start = 1'b1; tsa_p2c = 1'b1; tick; poll_start = 1'b0; tsa_p2c = 1'b0;
    checks++;
    if (poll_state !== 3'd2 || goto_cfg !== 1'b0 || ts_update !== 1'b0) begin
      failures++;
      $display("FAIL active_ignores got state=%0d cfg=%b upd=%b exp 2 0 0", poll_state, goto_cfg, ts_update);
    end
    tx_ts_strobe = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      checks++;
      if (enough !== 1'b0) begin
        failures++;
        $display("FAIL act_enough_early strobe=%0d got=%b exp=0", i, enough);
      end
    end
    tx_ts_strobe = 1'b0; tick;
    checks++;
    if (enough !== 1'b1) begin
      failures++;
      $display("FAIL act_enough got=%b exp=1", enough);
    end
    tsa_p_a2c = 1'b1; tick; tsa_p_a2c = 1'b0;
    checks++;
    if (poll_state !== 3'd3 || ts_info !== 8'h2C || ts_update !== 1'b1 || enough !== 1'b0) begin
      failures++;
      $display("FAIL cfg_req_entry got state=%0d info=%h upd=%b enough=%b exp 3 2c 1 0",
               poll_state, ts_info, ts_update, enough);
    end
    ts_update_ack = 1'b1; tick; ts_update_ack = 1'b0;
    checks++;
    if (poll_state !== 3'd4 || ts_update !== 1'b0 || ts_info !== 8'h2C) begin
      failures++;
      $display("FAIL config_entry got state=%0d upd=%b info=%h exp 4 0 2c", poll_state, ts_update, ts_info);
    end
    tx_ts_strobe = 1'b1; tick; tick; tick; tick; tx_ts_strobe = 1'b0;
    checks++;
    if (enough !== 1'b0) begin
      failures++;
      $display("FAIL cfg_enough_early got=%b exp=0", enough);
    end
    tick;
    checks++;
    if (enough !== 1'b1) begin
      failures++;
      $display("FAIL cfg_enough got=%b exp=1", enough);
    end
    tsa_p2c = 1'b1; tick; tsa_p2c = 1'b0;
    checks++;
    if ({goto_cfg, goto_detect, ts_stop} !== 3'b101 || poll_state !== 3'd0 || enough !== 1'b0) begin
      failures++;
      $display("FAIL cfg_exit got cfg/det/stop=%b state=%0d enough=%b exp 101 0 0",
               {goto_cfg, goto_detect, ts_stop}, poll_state, enough);
    end
    tick;
    checks++;
    if ({goto_cfg, goto_detect, ts_stop} !== 3'b000 || poll_state !== 3'd0) begin
      failures++;
      $display("FAIL cfg_exit_pulse got cfg/det/stop=%b state=%0d exp 000 0",
               {goto_cfg, goto_detect, ts_stop}, poll_state);
    end
  endtask

  task automatic test_act_timeout;
    int n;
    poll_start = 1'b1; tick; poll_start = 1'b0;
    ts_update_ack = 1'b1; tick; ts_update_ack = 1'b0;
    n = 1;
    while (n < 300 && goto_detect !== 1'b1) begin tick; n++; end
    checks++;
    if (n !== 200) begin
      failures++;
      $display("FAIL act_timeout_cycle got=%0d exp=200", n);
    end
    checks++;
    if (poll_state !== 3'd0 || ts_stop !== 1'b1 || goto_cfg !== 1'b0) begin
      failures++;
      $display("FAIL act_timeout_exit got state=%0d stop=%b cfg=%b exp 0 1 0", poll_state, ts_stop, goto_cfg);
    end
    tick;
    checks++;
    if (goto_detect !== 1'b0 || ts_stop !== 1'b0) begin
      failures++;
      $display("FAIL act_timeout_pulse got det=%b stop=%b exp 0 0", goto_detect, ts_stop);
    end
  endtask

  task automatic test_stall;
    int n;
    int bad;
    bad = 0;
    poll_start = 1'b1; tick; poll_start = 1'b0;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      if (ts_update !== 1'b1 || ts_info !== 8'h2A || poll_state !== 3'd1) bad++;
      if (k < 49) begin tick; n++; end
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stall_hold got bad_cycles=%0d exp=0", bad);
    end
    ts_update_ack = 1'b1; tick; ts_update_ack = 1'b0; n++;
    checks++;
    if (poll_state !== 3'd2 || ts_update !== 1'b0 || n !== 50) begin
      failures++;
      $display("FAIL stall_release got state=%0d upd=%b n=%0d exp 2 0 50", poll_state, ts_update, n);
    end
    while (n < 300 && goto_detect !== 1'b1) begin tick; n++; end
    checks++;
    if (n !== 200) begin
      failures++;
      $display("FAIL stall_timer_kept got=%0d exp=200", n);
    end
  endtask

  task automatic test_cfg_timeout;
    int n;
    enter_cfg_req;
    ts_update_ack = 1'b1; tick; ts_update_ack = 1'b0;
    n = 1;
    while (n < 600 && goto_detect !== 1'b1) begin tick; n++; end
    checks++;
    if (n !== 400 || goto_cfg !== 1'b0 || ts_stop !== 1'b1 || poll_state !== 3'd0) begin
      failures++;
      $display("FAIL cfg_timeout got n=%0d cfg=%b stop=%b state=%0d exp 400 0 1 0",
               n, goto_cfg, ts_stop, poll_state);
    end
    tick;
  endtask

  task automatic test_collision;
    int n;
    int spurious;
    spurious = 0;
    enter_cfg_req;
    ts_update_ack = 1'b1; tick; ts_update_ack = 1'b0;
    n = 1;
    while (n < 399) begin
      tick; n++;
      if (goto_cfg || goto_detect) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("FAIL collision_early_exit got=%0d exp=0", spurious);
    end
    tsa_p2c = 1'b1; tick; tsa_p2c = 1'b0;
    checks++;
    if (goto_cfg !== 1'b1 || goto_detect !== 1'b0) begin
      failures++;
      $display("FAIL collision_priority got cfg=%b det=%b exp 1 0", goto_cfg, goto_detect);
    end
    tick;
  endtask

  task automatic test_saturation;
    int drops;
    drops = 0;
    s_poll_start = 1'b1; tick; s_poll_start = 1'b0;
    s_ack = 1'b1; tick; s_ack = 1'b0;
    s_strobe = 1'b1;
    for (int k = 1; k <= 70000; k++) begin
      tick;
      if (k >= 9 && s_enough !== 1'b1) drops++;
    end
    s_strobe = 1'b0;
    checks++;
    if (drops !== 0) begin
      failures++;
      $display("FAIL sat_enough_drops got=%0d exp=0", drops);
    end
    checks++;
    if (u_sat.sent_q !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_count got=%h exp=ffff", u_sat.sent_q);
    end
    tick;
    checks++;
    if (s_enough !== 1'b1 || s_state !== 3'd2 ||
        {s_ts_info, s_ts_update, s_ts_stop, s_goto_cfg, s_goto_detect} !== 12'h2A0) begin
      failures++;
      $display("FAIL sat_state got enough=%b state=%0d misc=%h exp 1 2 2a0", s_enough, s_state,
               {s_ts_info, s_ts_update, s_ts_stop, s_goto_cfg, s_goto_detect});
    end
  endtask

  task automatic test_async_reset;
    enter_cfg_req;
    checks++;
    if (poll_state !== 3'd3 || ts_update !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup got state=%0d upd=%b exp 3 1", poll_state, ts_update);
    end
    #2; rst = 1'b1; #1;
    checks++;
    if ({ts_info, ts_update, ts_stop, enough, poll_state, goto_cfg, goto_detect} !== 16'h0) begin
      failures++;
      $display("FAIL areset_outputs got=%h exp=0000",
               {ts_info, ts_update, ts_stop, enough, poll_state, goto_cfg, goto_detect});
    end
    #2; rst = 1'b0;
    tick; tick;
    checks++;
    if (poll_state !== 3'd0 || ts_update !== 1'b0) begin
      failures++;
      $display("FAIL areset_no_restart got state=%0d upd=%b exp 0 0", poll_state, ts_update);
    end
    poll_start = 1'b1; tick; poll_start = 1'b0;
    checks++;
    if (poll_state !== 3'd1 || ts_info !== 8'h2A || ts_update !== 1'b1) begin
      failures++;
      $display("FAIL areset_restart got state=%0d info=%h upd=%b exp 1 2a 1", poll_state, ts_info, ts_update);
    end
    ts_update_ack = 1'b1; tick; ts_update_ack = 1'b0;
    checks++;
    if (poll_state !== 3'd2) begin
      failures++;
      $display("FAIL areset_active got state=%0d exp 2", poll_state);
    end
  endtask

  initial begin
    test_reset;
    test_happy_path;
    test_act_timeout;
    test_stall;
    test_cfg_timeout;
    test_collision;
    test_saturation;
    test_async_reset;
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL exits_exclusive got=%0d exp=0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
